rv32zhinx_arbiter: RTL and testbench
====================================

# rv32zhinx_arbiter

Two-requester round-robin controller that shares a single half-precision Zhinx FPU instance (start/done handshake, 32-bit operands) between two issuers, e.g. the scalar pipeline and a coprocessor port. It latches the winning request and pulses the FPU start. It holds operands stable until done, then returns the result to the owning requester. A watchdog aborts operations that never complete.

## Interface
- TIMEOUT_CYCLES, 64: maximum WAIT cycles before abort; legal range 2..1024.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset; synchronous, active-high.
- reqN_valid  in  1  (N=0,1) request present; payload stable while valid && !ready.
- reqN_op  in  fpu_opcode_t  operation.
- reqN_a, reqN_b  in  32  operands.
- reqN_ready  out  1  request accepted this cycle.
- respN_valid  out  1  result available for requester N.
- respN_ready  in  1  requester N consumes result.
- respN_data  out  32  result.
- respN_err  out  1  result produced by timeout abort.
- fpu_start  out  1  one-cycle start pulse to FPU.
- fpu_operation  out  fpu_opcode_t  latched op.
- fpu_a, fpu_b  out  32  latched operands.
- fpu_done  in  1  FPU completion.
- fpu_out  in  32  FPU result, valid when fpu_done.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Round-robin pointer rr (1 bit) gives priority to requester rr.
- IDLE: if any reqN_valid, winner = rr if its valid, else the other. reqW_ready=1 (combinational, IDLE only). Latch op/a/b and owner. Go to ISSUE.
- ISSUE: fpu_start=1 for exactly this cycle. Clear watchdog. If fpu_done is already high, capture fpu_out and go to RESP. Otherwise go to WAIT.
- WAIT: fpu_start=0; fpu_operation/a/b held at latched values. On fpu_done, capture fpu_out, err=0, go to RESP. Else if the watchdog reaches TIMEOUT_CYCLES-1, set data=32'h0000_7E00 (canonical half qNaN) and err=1, then go to RESP. Otherwise increment the watchdog.
- RESP: respOwner_valid=1, data/err held stable. The other resp_valid stays 0. On respOwner_ready, rr = ~owner and go to IDLE.
- fpu_done in IDLE or RESP is ignored. This includes a late done after a timeout.
- No new request is accepted until RESP completes. Throughput is one operation in flight.
- Watchdog width is $clog2(TIMEOUT_CYCLES); it saturates and never wraps.

## Timing
- Reset values: all outputs 0, state IDLE, rr=0, latches 0, watchdog 0.
- RST high in any state returns the block to IDLE on the next edge. No start pulse is issued, and any pending response is discarded.
- Accept at cycle T (valid&&ready), fpu_start at T+1. If done arrives at cycle D, resp_valid is asserted at D+1. Minimum accept-to-resp is 2 cycles (done at T+1).
- Timeout: resp_valid at T+2+TIMEOUT_CYCLES when done never arrives.
- resp_valid with respN_ready=1 returns to IDLE next cycle. The next accept occurs no earlier than one cycle after the resp handshake.
- Simultaneous valids: the winner is rr; the loser sees ready=0 and is served next.

## Structure
- rv32zhinx_pkg: arb_state_t enum {IDLE, ISSUE, WAIT, RESP}, RV32ZHINX_TIMEOUT_DEFAULT=64, HALF_QNAN=32'h0000_7E00.
- fpu_opcode_t comes from fpu_types_pkg.
- Sub-module rv32zhinx_watchdog: clear/enable/expired counter parameterised by TIMEOUT_CYCLES. The arbiter instantiates it once.
- The top level of the datapath instantiates the arbiter alongside rv32zhinx_wrapper, with fpu_* ports tied to the wrapper's start/operation/a/b/done/out.

## Test plan
- Single request: req0 ADD with FPU model latency 3. Required: ready at T, start at T+1 only, resp0_valid at T+5 with the model result, err=0, resp1_valid=0 throughout.
- Contention: both valid at reset exit. Required: req0 served first, rr=1 afterwards. With both still valid, req1 is served next, then req0. Grant order alternates 0,1,0,1.
- Zero-latency FPU: done asserted in the ISSUE cycle. Required: resp at T+2, data matches.
- Timeout: TIMEOUT_CYCLES=8 and done never asserted. Required: resp_valid at T+10, data=0x0000_7E00, err=1. A late done in IDLE is ignored, and the next request completes normally.
- Backpressure and reset: hold resp0_ready=0 for 5 cycles. Required: data stable and no new accept. Then assert RST during WAIT. Required: all outputs 0 next cycle, state IDLE, rr=0.

Source files
------------

// File: rtl/fpu_types_pkg.sv
// Operation codes understood by the shared half-precision Zhinx FPU.
package fpu_types_pkg;

  typedef enum logic [3:0] {
    FPU_ADD  = 4'd0,
    FPU_SUB  = 4'd1,
    FPU_MUL  = 4'd2,
    FPU_DIV  = 4'd3,
    FPU_SQRT = 4'd4,
    FPU_MIN  = 4'd5,
    FPU_MAX  = 4'd6,
    FPU_CMP  = 4'd7
  } fpu_opcode_t;

endpackage

// File: rtl/rv32zhinx_pkg.sv
// Shared types and constants for the Zhinx FPU arbiter.
package rv32zhinx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int          RV32ZHINX_TIMEOUT_DEFAULT = 64;
  localparam logic [31:0] HALF_QNAN                 = 32'h0000_7E00;

endpackage

// File: rtl/rv32zhinx_watchdog.sv
// Saturating cycle counter; expired is high once TIMEOUT_CYCLES-1 enabled cycles have elapsed.
module rv32zhinx_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int             CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/rv32zhinx_arbiter.sv
// Round-robin arbiter sharing one Zhinx FPU between two requesters.
// One operation in flight; a missing done becomes a qNaN error response.
module rv32zhinx_arbiter
  import rv32zhinx_pkg::*;
  import fpu_types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = RV32ZHINX_TIMEOUT_DEFAULT,
  parameter int DATA_W         = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  input  fpu_opcode_t       req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              req0_ready,

  input  logic              req1_valid,
  input  fpu_opcode_t       req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              req1_ready,

  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [DATA_W-1:0] resp0_data,
  output logic              resp0_err,

  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp1_data,
  output logic              resp1_err,

  output logic              fpu_start,
  output fpu_opcode_t       fpu_operation,
  output logic [DATA_W-1:0] fpu_a,
  output logic [DATA_W-1:0] fpu_b,
  input  logic              fpu_done,
  input  logic [DATA_W-1:0] fpu_out
);

  arb_state_t        state_q, state_d;
  logic              rr_q;
  logic              owner_q;
  fpu_opcode_t       op_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;

  logic win;
  logic grant;
  logic resp_take;
  logic wd_clear, wd_enable, wd_expired;
  logic capture_done, capture_timeout;

  // Priority goes to rr; the other requester wins only when rr is not asking.
  assign win       = rr_q ? req1_valid : ~req0_valid;
  assign grant     = (state_q == IDLE) && (req0_valid || req1_valid) && !rst;
  assign resp_take = (state_q == RESP) && (owner_q ? resp1_ready : resp0_ready);

  rv32zhinx_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  always_comb begin
    state_d         = state_q;
    fpu_start       = 1'b0;
    wd_clear        = 1'b0;
    wd_enable       = 1'b0;
    capture_done    = 1'b0;
    capture_timeout = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant) state_d = ISSUE;
      end
      ISSUE: begin
        fpu_start = 1'b1;
        wd_clear  = 1'b1;
        if (fpu_done) begin
          capture_done = 1'b1;
          state_d      = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (fpu_done) begin
          capture_done = 1'b1;
          state_d      = RESP;
        end else if (wd_expired) begin
          capture_timeout = 1'b1;
          state_d         = RESP;
        end else begin
          wd_enable = 1'b1;
        end
      end
      RESP: begin
        if (resp_take) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      op_q    <= FPU_ADD;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q <= win;
        op_q    <= win ? req1_op : req0_op;
        a_q     <= win ? req1_a  : req0_a;
        b_q     <= win ? req1_b  : req0_b;
      end
      if (capture_done) begin
        data_q <= fpu_out;
        err_q  <= 1'b0;
      end else if (capture_timeout) begin
        data_q <= DATA_W'(HALF_QNAN);
        err_q  <= 1'b1;
      end
      if (resp_take) rr_q <= ~owner_q;
    end
  end

  assign req0_ready    = grant && !win;
  assign req1_ready    = grant &&  win;

  assign resp0_valid   = (state_q == RESP) && !owner_q;
  assign resp1_valid   = (state_q == RESP) &&  owner_q;
  assign resp0_data    = owner_q ? '0 : data_q;
  assign resp1_data    = owner_q ? data_q : '0;
  assign resp0_err     = !owner_q && err_q;
  assign resp1_err     =  owner_q && err_q;

  assign fpu_operation = op_q;
  assign fpu_a         = a_q;
  assign fpu_b         = b_q;

endmodule

// File: tb/tb_rv32zhinx_arbiter.sv
// Directed bench for rv32zhinx_arbiter with a transaction-timeline model and an FPU stub.
module tb_rv32zhinx_arbiter;
  import fpu_types_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  fpu_opcode_t req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
  logic [31:0] resp0_data, resp1_data;
  logic        resp0_err, resp1_err;
  logic        fpu_start, fpu_done;
  fpu_opcode_t fpu_operation;
  logic [31:0] fpu_a, fpu_b, fpu_out;

  rv32zhinx_arbiter #(.TIMEOUT_CYCLES(TO), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data), .resp0_err(resp0_err),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data), .resp1_err(resp1_err),
    .fpu_start(fpu_start), .fpu_operation(fpu_operation), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_done(fpu_done), .fpu_out(fpu_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] fmodel(input fpu_opcode_t op, input logic [31:0] a, input logic [31:0] b);
    return a + b + 32'(op);
  endfunction

  // FPU stub: answers fpu_lat cycles after start (0 = same cycle, negative = never).
  int   fpu_lat = 1;
  int   fpu_cnt = 0;
  logic stray = 1'b0;
  initial begin
    fpu_done = 1'b0;
    fpu_out  = '0;
    forever begin
      @(posedge clk); #1;
      fpu_done = 1'b0;
      if (fpu_start) begin
        fpu_out = fmodel(fpu_operation, fpu_a, fpu_b);
        if (fpu_lat == 0) fpu_done = 1'b1;
        else fpu_cnt = fpu_lat;
      end else if (fpu_cnt > 0) begin
        fpu_cnt--;
        if (fpu_cnt == 0) fpu_done = 1'b1;
      end
      if (stray) begin
        fpu_done = 1'b1;
        fpu_out  = 32'hDEAD_BEEF;
      end
    end
  end

  // Timeline model: one transaction in flight, identified by accept and response cycles.
  bit          m_busy = 0, m_own = 0, m_rr = 0, m_err = 0;
  int          m_tacc = 0, m_tresp = -1;
  fpu_opcode_t m_op = FPU_ADD;
  logic [31:0] m_a = '0, m_b = '0, m_data = '0;

  task automatic model_step();
    logic [1:0] rv, rr_in;
    bit         win, gnt, in_resp;
    rv      = {req1_valid, req0_valid};
    rr_in   = {resp1_ready, resp0_ready};
    win     = rv[m_rr] ? m_rr : !m_rr;
    gnt     = !m_busy && !rst && (rv != 2'b00);
    in_resp = m_busy && (m_tresp >= 0) && (cyc >= m_tresp);

    chk("req0_ready", 32'(req0_ready), 32'(gnt && !win));
    chk("req1_ready", 32'(req1_ready), 32'(gnt && win));
    chk("fpu_start", 32'(fpu_start), 32'(m_busy && (cyc == m_tacc + 1)));
    chk("resp0_valid", 32'(resp0_valid), 32'(in_resp && !m_own));
    chk("resp1_valid", 32'(resp1_valid), 32'(in_resp && m_own));
    chk("fpu_operation", 32'(fpu_operation), 32'(m_op));
    chk("fpu_a", fpu_a, m_a);
    chk("fpu_b", fpu_b, m_b);
    if (in_resp) begin
      chk("resp_data", m_own ? resp1_data : resp0_data, m_data);
      chk("resp_err", 32'(m_own ? resp1_err : resp0_err), 32'(m_err));
    end

    if (rst) begin
      m_busy = 0; m_rr = 0; m_op = FPU_ADD; m_a = '0; m_b = '0;
    end else if (gnt) begin
      m_busy = 1; m_own = win; m_tacc = cyc; m_tresp = -1;
      m_op = win ? req1_op : req0_op;
      m_a  = win ? req1_a  : req0_a;
      m_b  = win ? req1_b  : req0_b;
    end else if (m_busy && m_tresp < 0) begin
      if (cyc >= m_tacc + 1 && fpu_done) begin
        m_tresp = cyc + 1; m_data = fpu_out; m_err = 0;
      end else if (cyc == m_tacc + 1 + TO) begin
        m_tresp = cyc + 1; m_data = 32'h0000_7E00; m_err = 1;
      end
    end else if (in_resp && rr_in[m_own]) begin
      m_busy = 0; m_rr = !m_own;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      model_step();
    end
  end

  task automatic do_req(input int n, input fpu_opcode_t op, input logic [31:0] a, input logic [31:0] b,
                        output int t_acc);
    bit got;
    got = 0;
    t_acc = -1;
    if (n == 0) begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
    else        begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if ((n == 0) ? req0_ready : req1_ready) begin
        got = 1;
        t_acc = cyc;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL accept%0d got=no_grant expected=grant_within_40", n);
    end
    @(posedge clk); #1;
    if (n == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  task automatic wait_resp(input int n, output int t);
    bit got;
    got = 0;
    t = -1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if ((n == 0) ? resp0_valid : resp1_valid) begin
        got = 1;
        t = cyc;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL resp%0d got=no_resp expected=resp_within_40", n);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req0_ready"}, 32'(req0_ready), 0);
    chk({tag, "_req1_ready"}, 32'(req1_ready), 0);
    chk({tag, "_resp0_valid"}, 32'(resp0_valid), 0);
    chk({tag, "_resp1_valid"}, 32'(resp1_valid), 0);
    chk({tag, "_resp0_data"}, resp0_data, 0);
    chk({tag, "_resp1_data"}, resp1_data, 0);
    chk({tag, "_resp_err"}, 32'({resp1_err, resp0_err}), 0);
    chk({tag, "_fpu_start"}, 32'(fpu_start), 0);
    chk({tag, "_fpu_operation"}, 32'(fpu_operation), 0);
    chk({tag, "_fpu_a"}, fpu_a, 0);
    chk({tag, "_fpu_b"}, fpu_b, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int t, tr;
    logic [3:0] order;
    bit got;
    rst = 1;
    req0_valid = 0; req1_valid = 0;
    req0_op = FPU_ADD; req1_op = FPU_ADD;
    req0_a = '0; req0_b = '0; req1_a = 32'h100; req1_b = 32'h1;
    resp0_ready = 1; resp1_ready = 1;

    // Reset state, then contention straight out of reset.
    @(posedge clk); @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 0;
    fpu_lat = 1;
    req0_valid = 1; req1_valid = 1;
    order = '0;
    for (int g = 0; g < 4; g++) begin
      got = 0;
      for (int k = 0; k < 40 && !got; k++) begin
        @(negedge clk);
        if (req0_ready) begin order[g] = 1'b0; got = 1; end
        else if (req1_ready) begin order[g] = 1'b1; got = 1; end
      end
      checks++;
      if (!got) begin
        failures++;
        $display("FAIL contention_grant%0d got=none expected=grant", g);
      end
      @(posedge clk); #1;
      if (order[g] == 1'b0) req0_a = req0_a + 1; else req1_a = req1_a + 1;
    end
    req0_valid = 0; req1_valid = 0;
    chk("grant_order", 32'(order), 32'h0000_000A);
    wait_resp(1, tr);
    @(posedge clk); #1;

    // Single request, latency 3.
    fpu_lat = 3;
    do_req(0, FPU_ADD, 32'h0000_3C00, 32'h0000_4000, t);
    wait_resp(0, tr);
    chk("lat3_delay", 32'(tr - t), 5);
    chk("lat3_data", resp0_data, 32'h0000_7C00);
    chk("lat3_err", 32'(resp0_err), 0);
    @(posedge clk); #1;

    // Zero-latency FPU.
    fpu_lat = 0;
    do_req(1, FPU_MUL, 32'h0000_0100, 32'h0000_0020, t);
    wait_resp(1, tr);
    chk("lat0_delay", 32'(tr - t), 2);
    chk("lat0_data", resp1_data, 32'h0000_0122);
    @(posedge clk); #1;

    // Timeout, then a stray done in IDLE, then a normal request.
    fpu_lat = -1;
    do_req(0, FPU_DIV, 32'h1, 32'h2, t);
    wait_resp(0, tr);
    chk("timeout_delay", 32'(tr - t), 10);
    chk("timeout_data", resp0_data, 32'h0000_7E00);
    chk("timeout_err", 32'(resp0_err), 1);
    @(negedge clk);
    stray = 1;
    @(negedge clk);
    stray = 0;
    chk("stray_start", 32'(fpu_start), 0);
    chk("stray_resp0", 32'(resp0_valid), 0);
    @(posedge clk); #1;
    fpu_lat = 2;
    do_req(0, FPU_SUB, 32'h5, 32'h6, t);
    wait_resp(0, tr);
    chk("after_timeout_delay", 32'(tr - t), 4);
    chk("after_timeout_data", resp0_data, 32'h0000_000C);
    chk("after_timeout_err", 32'(resp0_err), 0);
    @(posedge clk); #1;

    // Backpressure: result held, no new accept.
    fpu_lat = 1;
    resp0_ready = 0;
    do_req(0, FPU_MAX, 32'h10, 32'h20, t);
    wait_resp(0, tr);
    @(posedge clk); #1;
    req1_valid = 1; req1_op = FPU_MIN; req1_a = 32'h55; req1_b = 32'h66;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_data", resp0_data, 32'h0000_0036);
      chk("bp_valid", 32'(resp0_valid), 1);
      chk("bp_no_accept", 32'(req1_ready), 0);
    end
    @(posedge clk); #1;
    resp0_ready = 1;
    fpu_lat = -1;
    do_req(1, FPU_MIN, 32'h55, 32'h66, t);

    // Reset while waiting on the FPU.
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk_all_zero("rst_wait");
    @(posedge clk); #1;
    fpu_lat = 1;
    req0_valid = 1; req1_valid = 1;
    got = 0;
    order = '0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (req0_ready) begin order[0] = 1'b0; got = 1; end
      else if (req1_ready) begin order[0] = 1'b1; got = 1; end
    end
    chk("post_reset_winner_found", 32'(got), 1);
    chk("post_reset_winner", 32'(order[0]), 0);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    wait_resp(0, tr);
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
